// File: rtl/is_skew_feeder_pkg.sv
// Shared definitions for the skewed activation feeder and its input FIFO:
// FSM encodings, FIFO entry layout and a width helper.
package is_skew_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

  // FIFO entries are packed as {last, data}: the tile-end flag sits above the data bits.
  function automatic int unsigned entry_width(input int unsigned data_w);
    return data_w + 1;
  endfunction

  // Ceil-log2 that never returns 0, so a 1-entry range still gets a 1-bit field.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO with synchronous clear; shared by the activation and weight feeders.
module sa_sync_fifo
  import is_skew_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = clog2_min1(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/is_skew_feeder.sv
// Activation feeder for the input-stationary array: buffers row vectors and
// drives row i delayed by i cycles, with per-row valid and tile start/done pulses.
module is_skew_feeder
  import is_skew_feeder_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int WIDTH_A = 16,
  parameter int DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    soft_clr,
  input  logic                    pipeline_en,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [ROWS*WIDTH_A-1:0] s_data,
  input  logic                    s_last,
  output logic [ROWS*WIDTH_A-1:0] a_out,
  output logic [ROWS-1:0]         a_valid,
  output logic                    tile_start,
  output logic                    tile_done
);
  localparam int VW = ROWS * WIDTH_A;
  localparam int EW = entry_width(VW);
  localparam int FW = clog2_min1(ROWS) + 1;
  localparam logic [FW-1:0] FLUSH_INIT = FW'(ROWS - 1);

  feed_state_e   state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          lock_q, lock_d;
  logic          alive_q;
  logic          tile_start_q, tile_done_q;
  logic          pop, push, tile_first, done_now;
  logic          fifo_full, fifo_empty;
  logic [EW-1:0] fifo_din, fifo_dout;

  assign s_ready  = alive_q & ~lock_q & ~fifo_full;
  assign push     = s_valid & s_ready & ~soft_clr;
  assign fifo_din = {s_last, s_data};

  sa_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (soft_clr),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pop        = 1'b0;
    tile_first = 1'b0;
    done_now   = 1'b0;
    if (pipeline_en) begin
      case (state_q)
        ST_IDLE, ST_FEED: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            tile_first = (state_q == ST_IDLE);
            state_d    = ST_FEED;
            if (fifo_dout[EW-1]) begin
              if (ROWS == 1) begin
                state_d = ST_DONE;
              end else begin
                state_d = ST_FLUSH;
                fcnt_d  = FLUSH_INIT;
              end
            end
          end
        end
        ST_FLUSH: begin
          fcnt_d = fcnt_q - 1'b1;
          if (fcnt_q <= FW'(1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          done_now = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Accepting s_last takes priority; the lock drops once tile_done has been seen by an enabled edge.
  always_comb begin
    lock_d = lock_q;
    if (push && s_last)                  lock_d = 1'b1;
    else if (tile_done_q && pipeline_en) lock_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fcnt_q       <= '0;
      lock_q       <= 1'b0;
      alive_q      <= 1'b0;
      tile_start_q <= 1'b0;
      tile_done_q  <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (soft_clr) begin
        state_q      <= ST_IDLE;
        fcnt_q       <= '0;
        lock_q       <= 1'b0;
        tile_start_q <= 1'b0;
        tile_done_q  <= 1'b0;
      end else begin
        lock_q <= lock_d;
        if (pipeline_en) begin
          state_q      <= state_d;
          fcnt_q       <= fcnt_d;
          tile_start_q <= tile_first;
          tile_done_q  <= done_now;
        end
      end
    end
  end

  assign tile_start = tile_start_q;
  assign tile_done  = tile_done_q;

  // Row r is an (r+1)-deep shift register; index 0 is newest, index r drives the array.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0][WIDTH_A-1:0] dat_q, dat_d;
    logic [r:0]              vld_q, vld_d;
    logic [WIDTH_A-1:0]      head;

    assign head = pop ? fifo_dout[r*WIDTH_A +: WIDTH_A] : '0;

    if (r == 0) begin : g_head
      assign dat_d = head;
      assign vld_d = pop;
    end else begin : g_shift
      assign dat_d = {dat_q[r-1:0], head};
      assign vld_d = {vld_q[r-1:0], pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dat_q <= '0;
        vld_q <= '0;
      end else if (soft_clr) begin
        dat_q <= '0;
        vld_q <= '0;
      end else if (pipeline_en) begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign a_out[r*WIDTH_A +: WIDTH_A] = dat_q[r];
    assign a_valid[r]                  = vld_q[r];
  end

endmodule
